// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong ball engine:
//   - state_e      : engine sequencing states
//   - DIR_POS/NEG  : encoding of one movement direction bit (+1 / -1)
//   - TOP_*/DN_*   : bit positions inside the 8-bit paddle contact flags
//   - SERVE_X      : column the ball is served from
//   - paddle_bounce: decides whether a paddle row returns the ball and with
//                    which horizontal direction
// ---------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    localparam int TOP_L = 0;
    localparam int TOP_C = 1;
    localparam int TOP_R = 2;
    localparam int DN_L  = 5;
    localparam int DN_C  = 6;
    localparam int DN_R  = 7;

    localparam int SERVE_X = 3;

    typedef struct packed {
        logic ret;   // paddle returned the ball
        logic dx;    // horizontal direction after the contact
    } bounce_t;

    // Same rule for both paddles: the centre segment always returns with dx
    // unchanged; an edge segment only returns a ball travelling towards it,
    // and sends it back the other way horizontally.
    function automatic bounce_t paddle_bounce(input logic seg_l,
                                              input logic seg_c,
                                              input logic seg_r,
                                              input logic dx);
        bounce_t res;
        res.ret = 1'b0;
        res.dx  = dx;
        if (seg_c) begin
            res.ret = 1'b1;
        end else if (seg_l && (dx == DIR_NEG)) begin
            res.ret = 1'b1;
            res.dx  = DIR_POS;
        end else if (seg_r && (dx == DIR_POS)) begin
            res.ret = 1'b1;
            res.dx  = DIR_NEG;
        end
        return res;
    endfunction

endpackage

// File: rtl/ball_engine_if.sv
// ---------------------------------------------------------------------------
// ball_engine_if
// Signal bundle between the ball engine and its surroundings.
//   start      : level request to (re)start a game
//   hit        : paddle contact flags from the collision stage
//   x_pos/y_pos: ball position read by the collision stage
//   score_top/score_down, point, game_over, winner : game status
// Modports:
//   master : the side driving start/hit (collision stage / testbench)
//   slave  : the ball engine itself
// ---------------------------------------------------------------------------
interface ball_engine_if #(
    parameter int WIDTH        = 8,
    parameter int BIT_OF_WIDTH = 3,
    parameter int SCORE_BITS   = 4
);
    logic                    start;
    logic [WIDTH-1:0]        hit;
    logic [BIT_OF_WIDTH-1:0] x_pos;
    logic [BIT_OF_WIDTH-1:0] y_pos;
    logic [SCORE_BITS-1:0]   score_top;
    logic [SCORE_BITS-1:0]   score_down;
    logic                    point;
    logic                    game_over;
    logic                    winner;

    modport master (
        output start, hit,
        input  x_pos, y_pos, score_top, score_down, point, game_over, winner
    );

    modport slave (
        input  start, hit,
        output x_pos, y_pos, score_top, score_down, point, game_over, winner
    );
endinterface

// File: rtl/step_timer.sv
// ---------------------------------------------------------------------------
// step_timer
// Free-running step tick generator. The counter runs 0..period-1 and wraps;
// tick is high for the single cycle in which the counter sits at period-1.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   rally_hit  : one-cycle strobe for each paddle return (speed-up only)
//   serve      : one-cycle strobe on a serve, restores the base period
//   tick       : step strobe
// Build option PONG_SPEEDUP_EN: when defined, every fourth paddle return
// shortens the period by STEP_CYCLES/8, never below STEP_CYCLES/4.
// Without it the period is fixed at STEP_CYCLES.
// ---------------------------------------------------------------------------
module step_timer #(
    parameter int STEP_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rally_hit,
    input  logic serve,
    output logic tick
);
    localparam int CNT_BITS = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(STEP_CYCLES - 1);

    logic [CNT_BITS-1:0] count_q, count_d;

`ifdef PONG_SPEEDUP_EN
    localparam logic [CNT_BITS-1:0] DEC        = CNT_BITS'(STEP_CYCLES / 8);
    localparam logic [CNT_BITS-1:0] FLOOR_LAST = CNT_BITS'(STEP_CYCLES / 4 - 1);
    localparam logic [CNT_BITS-1:0] SHRINK_MIN = CNT_BITS'(STEP_CYCLES / 4 - 1 + STEP_CYCLES / 8);

    // Period is stored as its last count value so the compare is direct.
    logic [CNT_BITS-1:0] period_last_q, period_last_d;
    logic [1:0]          rally_q, rally_d;

    // ">=" so a period shortened mid-count still wraps cleanly.
    assign tick = (count_q >= period_last_q);

    always_comb begin
        count_d       = tick ? '0 : count_q + 1'b1;
        period_last_d = period_last_q;
        rally_d       = rally_q;
        if (serve) begin
            period_last_d = LAST;
            rally_d       = '0;
        end else if (rally_hit) begin
            rally_d = rally_q + 1'b1;
            if (rally_q == 2'd3) begin
                if (period_last_q >= SHRINK_MIN) begin
                    period_last_d = period_last_q - DEC;
                end else begin
                    period_last_d = FLOOR_LAST;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= '0;
            period_last_q <= LAST;
            rally_q       <= '0;
        end else begin
            count_q       <= count_d;
            period_last_q <= period_last_d;
            rally_q       <= rally_d;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, rally_hit, serve};

    assign tick = (count_q == LAST);

    always_comb begin
        count_d = tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`endif

endmodule

// File: rtl/ball_engine.sv
// ---------------------------------------------------------------------------
// ball_engine
// Ball physics and game sequencing for the 8x8 pong playfield. Moves the ball
// one cell per step tick, reflects it off the side walls and the paddles
// (contact flags come in on bus.hit), scores misses and runs
// IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ball_engine_if.slave (start, hit in; position, scores,
//                point, game_over, winner out)
// Build option PONG_SPEEDUP_EN: enables rally speed-up inside step_timer.
// ---------------------------------------------------------------------------
module ball_engine
    import pong_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int BIT_OF_WIDTH = 3,
    parameter int STEP_CYCLES  = 1000000,
    parameter int POINT_STEPS  = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SCORE_BITS   = 4
) (
    input logic         clk,
    input logic         rst_n,
    ball_engine_if.slave bus
);
    localparam int HOLD_BITS = (POINT_STEPS > 1) ? $clog2(POINT_STEPS) : 1;

    localparam logic [BIT_OF_WIDTH-1:0] X_MIN       = BIT_OF_WIDTH'(1);
    localparam logic [BIT_OF_WIDTH-1:0] X_MAX       = BIT_OF_WIDTH'(WIDTH - 2);
    localparam logic [BIT_OF_WIDTH-1:0] ROW_TOP     = BIT_OF_WIDTH'(1);
    localparam logic [BIT_OF_WIDTH-1:0] ROW_DN      = BIT_OF_WIDTH'(WIDTH - 2);
    localparam logic [BIT_OF_WIDTH-1:0] OUT_TOP     = BIT_OF_WIDTH'(0);
    localparam logic [BIT_OF_WIDTH-1:0] OUT_DN      = BIT_OF_WIDTH'(WIDTH - 1);
    localparam logic [BIT_OF_WIDTH-1:0] HOME        = BIT_OF_WIDTH'(3);
    localparam logic [BIT_OF_WIDTH-1:0] SRV_X       = BIT_OF_WIDTH'(SERVE_X);
    localparam logic [BIT_OF_WIDTH-1:0] SRV_Y_DOWN  = BIT_OF_WIDTH'(3);
    localparam logic [BIT_OF_WIDTH-1:0] SRV_Y_UP    = BIT_OF_WIDTH'(4);
    localparam logic [SCORE_BITS-1:0]   WIN         = SCORE_BITS'(WIN_SCORE);
    localparam logic [HOLD_BITS-1:0]    HOLD_LAST   = HOLD_BITS'(POINT_STEPS - 1);

    state_e                  state_q, state_d;
    logic [BIT_OF_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic                    dx_q, dx_d, dy_q, dy_d;
    logic [SCORE_BITS-1:0]   score_top_q, score_top_d;
    logic [SCORE_BITS-1:0]   score_down_q, score_down_d;
    logic                    point_q, point_d;
    logic                    winner_q, winner_d;
    logic [HOLD_BITS-1:0]    hold_q, hold_d;

    logic    tick;
    logic    rally_hit;
    logic    serve_tick;
    bounce_t bounce;
    logic    nx, ny;
    logic    miss_top, miss_dn;

    step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .rally_hit (rally_hit),
        .serve     (serve_tick),
        .tick      (tick)
    );

    assign serve_tick = tick && (state_q == ST_SERVE);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        score_top_d  = score_top_q;
        score_down_d = score_down_q;
        point_d      = 1'b0;
        winner_d     = winner_q;
        hold_d       = hold_q;
        rally_hit    = 1'b0;
        bounce       = '0;
        nx           = dx_q;
        ny           = dy_q;
        miss_top     = 1'b0;
        miss_dn      = 1'b0;

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    x_d = HOME;
                    y_d = HOME;
                    if (bus.start) begin
                        state_d = ST_SERVE;
                    end
                end

                ST_SERVE: begin
                    x_d     = SRV_X;
                    y_d     = (dy_q == DIR_POS) ? SRV_Y_DOWN : SRV_Y_UP;
                    state_d = ST_PLAY;
                end

                ST_PLAY: begin
                    // Paddle rows only matter when the ball is moving into them.
                    if ((y_q == ROW_TOP) && (dy_q == DIR_NEG)) begin
                        bounce = paddle_bounce(bus.hit[TOP_L], bus.hit[TOP_C],
                                               bus.hit[TOP_R], dx_q);
                        if (bounce.ret) begin
                            ny        = DIR_POS;
                            nx        = bounce.dx;
                            rally_hit = 1'b1;
                        end else begin
                            miss_top = 1'b1;
                        end
                    end else if ((y_q == ROW_DN) && (dy_q == DIR_POS)) begin
                        bounce = paddle_bounce(bus.hit[DN_L], bus.hit[DN_C],
                                               bus.hit[DN_R], dx_q);
                        if (bounce.ret) begin
                            ny        = DIR_NEG;
                            nx        = bounce.dx;
                            rally_hit = 1'b1;
                        end else begin
                            miss_dn = 1'b1;
                        end
                    end

                    // Walls act on the post-paddle direction, so a corner
                    // return that already turned the ball is not undone.
                    if ((x_q == X_MIN) && (nx == DIR_NEG)) begin
                        nx = DIR_POS;
                    end else if ((x_q == X_MAX) && (nx == DIR_POS)) begin
                        nx = DIR_NEG;
                    end

                    dx_d = nx;
                    dy_d = ny;

                    if (miss_top) begin
                        score_down_d = (score_down_q == WIN) ? WIN : score_down_q + 1'b1;
                        y_d          = OUT_TOP;
                        point_d      = 1'b1;
                        hold_d       = '0;
                        state_d      = ST_POINT;
                    end else if (miss_dn) begin
                        score_top_d = (score_top_q == WIN) ? WIN : score_top_q + 1'b1;
                        y_d         = OUT_DN;
                        point_d     = 1'b1;
                        hold_d      = '0;
                        state_d     = ST_POINT;
                    end else begin
                        x_d = (nx == DIR_POS) ? x_q + 1'b1 : x_q - 1'b1;
                        y_d = (ny == DIR_POS) ? y_q + 1'b1 : y_q - 1'b1;
                    end
                end

                ST_POINT: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if ((score_top_q == WIN) || (score_down_q == WIN)) begin
                            winner_d = (score_down_q == WIN);
                            state_d  = ST_OVER;
                        end else begin
                            // y_pos still marks the side that conceded.
                            dy_d    = (y_q == OUT_TOP) ? DIR_NEG : DIR_POS;
                            dx_d    = ~dx_q;
                            state_d = ST_SERVE;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end

                ST_OVER: begin
                    if (bus.start) begin
                        score_top_d  = '0;
                        score_down_d = '0;
                        dx_d         = DIR_POS;
                        dy_d         = DIR_POS;
                        state_d      = ST_SERVE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            x_q          <= HOME;
            y_q          <= HOME;
            dx_q         <= DIR_POS;
            dy_q         <= DIR_POS;
            score_top_q  <= '0;
            score_down_q <= '0;
            point_q      <= 1'b0;
            winner_q     <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            score_top_q  <= score_top_d;
            score_down_q <= score_down_d;
            point_q      <= point_d;
            winner_q     <= winner_d;
            hold_q       <= hold_d;
        end
    end

    assign bus.x_pos      = x_q;
    assign bus.y_pos      = y_q;
    assign bus.score_top  = score_top_q;
    assign bus.score_down = score_down_q;
    assign bus.point      = point_q;
    assign bus.game_over  = (state_q == ST_OVER);
    assign bus.winner     = winner_q;

endmodule
